// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring 32-bit signed/unsigned divider for the EX stage.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes one cycle after start.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic        div_annul,
    input  logic [31:0] div_opdata1,
    input  logic [31:0] div_opdata2,
    output logic [63:0] div_result,
    output logic        div_ready,
    output logic        stallreq_for_div
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] orig_q, orig_d;
    logic        qs_q, qs_d, rs_q, rs_d, zero_q, zero_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] rem_sh, rem_sub;
    logic        ge, fast_zero;
    logic [31:0] q_n, rem_n;
    logic [63:0] fin;

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = div_opdata2 == '0;
`else
    assign fast_zero = 1'b0;
`endif

    // Borrow out of the trial subtraction decides the quotient bit.
    assign rem_sh  = {rem_q, dvd_q[31]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign ge      = ~rem_sub[32];
    assign rem_n   = ge ? rem_sub[31:0] : rem_sh[31:0];
    assign q_n     = {dvd_q[30:0], ge};
    assign fin     = zero_q ? {orig_q, 32'hFFFF_FFFF}
                            : {rs_q ? -rem_n : rem_n, qs_q ? -q_n : q_n};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        orig_d   = orig_q;
        qs_d     = qs_q;
        rs_d     = rs_q;
        zero_d   = zero_q;
        result_d = result_q;
        ready_d  = 1'b0;
        if (div_annul) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (div_start) begin
                    dvd_d   = (div_signed & div_opdata1[31]) ? -div_opdata1 : div_opdata1;
                    dvs_d   = (div_signed & div_opdata2[31]) ? -div_opdata2 : div_opdata2;
                    qs_d    = div_signed & (div_opdata1[31] ^ div_opdata2[31]);
                    rs_d    = div_signed & div_opdata1[31];
                    orig_d  = div_opdata1;
                    zero_d  = div_opdata2 == '0;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = fast_zero ? DONE : BUSY;
                    if (fast_zero) begin
                        ready_d  = 1'b1;
                        result_d = {div_opdata1, 32'hFFFF_FFFF};
                    end
                end
                BUSY: begin
                    rem_d = rem_n;
                    dvd_d = q_n;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = fin;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            orig_q   <= '0;
            qs_q     <= 1'b0;
            rs_q     <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            orig_q   <= orig_d;
            qs_q     <= qs_d;
            rs_q     <= rs_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign div_result       = result_q;
    assign div_ready        = ready_q;
    assign stallreq_for_div = (state_q == IDLE & div_start & ~div_annul) | state_q == BUSY;
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized self-checking bench for ex_div against an arithmetic reference model.
module tb_ex_div;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic        div_annul = 1'b0;
    logic [31:0] div_opdata1 = '0;
    logic [31:0] div_opdata2 = '0;
    logic [63:0] div_result;
    logic        div_ready;
    logic        stallreq_for_div;
    int          checks = 0;
    int          failures = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    ex_div dut (
        .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
        .div_annul(div_annul), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_result(div_result), .div_ready(div_ready), .stallreq_for_div(stallreq_for_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts at a fresh negedge, ends at the negedge where div_ready was seen (start dropped there).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int n, bad, lat;
        @(negedge clk);
        chk({tag, "_idle_ready"}, {63'd0, div_ready}, 64'd0);
        div_opdata1 = a; div_opdata2 = b; div_signed = s; div_start = 1'b1;
        #1 chk({tag, "_stall0"}, {63'd0, stallreq_for_div}, 64'd1);
        lat = (b == 0) ? ZLAT : 33;
        n = 0; bad = 0;
        while (!div_ready && n < 40) begin
            @(negedge clk);
            n++;
            if (div_ready) bad += stallreq_for_div ? 1 : 0;
            else bad += stallreq_for_div ? 0 : 1;
        end
        div_start = 1'b0;
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_stall"}, 64'(bad), 64'd0);
        chk({tag, "_res"}, div_result, ref_div(a, b, s));
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] a, b;
        int bad;
        #2 chk("rst_result", div_result, 64'd0);
        chk("rst_ready", {63'd0, div_ready}, 64'd0);
        chk("rst_stall", {63'd0, stallreq_for_div}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b0, "u100_7");
        chk("u100_7_exact", div_result, {32'd2, 32'd14});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
        chk("s_m7_2_exact", div_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "u_m7_2");
        chk("u_m7_2_exact", div_result, {32'h0000_0001, 32'h7FFF_FFFC});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        chk("s_ovf_exact", div_result, {32'd0, 32'h8000_0000});
        run_div(32'd5, 32'd0, 1'b0, "u_z");
        chk("u_z_exact", div_result, {32'd5, 32'hFFFF_FFFF});
        run_div(32'h8000_0003, 32'd0, 1'b1, "s_z");

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: b = $urandom;
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), "rnd");
        end

        // Annul ten cycles into an operation.
        held = div_result;
        @(negedge clk);
        div_opdata1 = 32'h1234_5678; div_opdata2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
        repeat (10) @(negedge clk);
        div_annul = 1'b1;
        @(negedge clk);
        div_annul = 1'b0; div_start = 1'b0;
        chk("annul_stall", {63'd0, stallreq_for_div}, 64'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            bad += div_ready ? 1 : 0;
        end
        chk("annul_noready", 64'(bad), 64'd0);
        chk("annul_held", div_result, held);
        run_div(32'd12345, 32'd10, 1'b0, "post_annul");
        chk("post_annul_exact", div_result, {32'd5, 32'd1234});

        // Annul and start together in IDLE: annul wins.
        @(negedge clk);
        div_opdata1 = 32'd9; div_opdata2 = 32'd3; div_start = 1'b1; div_annul = 1'b1;
        #1 chk("annul_start_stall", {63'd0, stallreq_for_div}, 64'd0);
        @(negedge clk);
        div_start = 1'b0; div_annul = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            bad += div_ready ? 1 : 0;
        end
        chk("annul_start_noready", 64'(bad), 64'd0);

        // Asynchronous reset mid-BUSY.
        @(negedge clk);
        div_opdata1 = 32'd1000; div_opdata2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1; div_start = 1'b0;
        #1 chk("arst_result", div_result, 64'd0);
        chk("arst_ready", {63'd0, div_ready}, 64'd0);
        chk("arst_stall", {63'd0, stallreq_for_div}, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_div(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1, "post_rst");
        chk("post_rst_exact", div_result, {32'd0, 32'd16});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit integer divider used by the EX stage for signed and unsigned divide instructions. It computes one quotient bit per cycle with radix-2 restoring division. It holds the pipeline through the stall bus while busy, then presents `{remainder, quotient}` for one cycle so EX can forward the result into the EX-to-MEM bus like any other ALU result.

## Interface
Parameters:
- none (width fixed at 32/64)

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `div_start` input 1 — level; operands valid, division requested (held by EX while instruction is stalled).
- `div_signed` input 1 — 1: two's-complement operands; 0: unsigned.
- `div_annul` input 1 — abort current operation (pipeline flush).
- `div_opdata1` input 32 — dividend.
- `div_opdata2` input 32 — divisor.
- `div_result` output 64 — `{remainder[63:32], quotient[31:0]}`.
- `div_ready` output 1 — result valid, exactly one cycle per completed division.
- `stallreq_for_div` output 1 — stall request into the stall controller.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `div_start=1` and `div_annul=0` → latch the operands and convert them to magnitudes (signed mode only). Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign). Clear the 5-bit counter and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: each cycle, shift the partial remainder left by one and bring in the next dividend magnitude bit (MSB first).
  - If the partial remainder ≥ the divisor magnitude: subtract, and the quotient bit is 1.
  - Otherwise the quotient bit is 0.
  - The counter increments every cycle; after the 32nd iteration (counter 31) go to DONE.
- DONE:
  - Apply the signs: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register `div_result` and assert `div_ready` for this cycle.
  - Go to IDLE unconditionally.
  - `div_start` is ignored in DONE. The instruction still present in EX must not restart.
- `div_result` holds its last value until the next DONE.
- Arithmetic:
  - Partial remainder is 33 bits wide.
  - Magnitude of 0x80000000 is 2^31 as an unsigned 32-bit value.
  - 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0. No trap.
- Divide by zero: the result is always quotient 0xFFFFFFFF and remainder = the original `div_opdata1`, in both signed and unsigned mode. This value is forced at DONE and overrides the sign correction.
- `div_annul`:
  - In any state, it returns the FSM to IDLE on the next edge.
  - `div_ready` stays 0 and `div_result` is unchanged.
  - If annul and start are both high in IDLE, annul wins.
- `stallreq_for_div` = (IDLE & `div_start` & ~`div_annul`) | BUSY. It is 0 in DONE so the instruction leaves EX with the result.
- Reset (mid-operation included): state IDLE, counter 0, `div_result`=0, `div_ready`=0, `stallreq_for_div`=0, internal operand and sign registers 0.

## Timing
- Start sampled at edge E0. BUSY covers edges E1..E32, DONE is the cycle after E32. `div_ready` is high during that DONE cycle, which is 33 cycles after the start cycle.
- `stallreq_for_div` is combinational from `div_start` in IDLE (same cycle). It deasserts in the DONE cycle.
- `div_result` and `div_ready` are registered outputs.
- Back-to-back divides: the next `div_start` is accepted in the IDLE cycle immediately after DONE (minimum issue interval 34 cycles).

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - In IDLE, a zero divisor at start goes directly to DONE, so `div_ready` comes 1 cycle after the start cycle.
  - The result is the divide-by-zero value above.
  - `stallreq_for_div` is high only in the start cycle.
- Not defined: a zero divisor runs the full 32 BUSY cycles, with the same forced result and 33-cycle latency.

## Test plan
- Unsigned 100 / 7 → `div_result`={0x00000002, 0x0000000E}; `div_ready` one cycle, 33 cycles after start; stall high for cycles 0..32.
- Signed 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. The same operands unsigned → quotient 0x7FFFFFFC, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0; no hang.
- Unsigned 5 / 0 → quotient 0xFFFFFFFF, remainder 5. Latency is 33 cycles without `DIV_ZERO_FAST_EN` and 1 cycle with it.
- Annul 10 cycles after start → IDLE next edge, no `div_ready`, stall low, previous `div_result` retained. A new start 12345/10 then yields {5, 1234}.
- `rst` asserted asynchronously mid-BUSY (not on a clock edge) → all outputs 0 immediately. After release, a fresh divide completes normally.
